// File: rtl/prod_accum.sv
// prod_accum: sums N_TERMS consecutive 8-bit products from the upstream
// multiplier and presents each total on a registered valid/ready output.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. in_ready depends only on the state and clr,
// never on in_valid. out_valid stays high, with sum_out stable, until a
// consume (out_valid & out_ready & !clr), a clr or a rst. A consume that
// coincides with clr is not a transfer; the held result is discarded.
module prod_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       prod_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       term_cnt
);

  // Reject configurations where the count range is unsupported or the
  // accumulator could overflow.
  if (N_TERMS < 2 || N_TERMS > 16) begin : g_bad_n_terms
    $error("prod_accum: N_TERMS must be in 2..16");
  end
  if (ACC_W < 8 + $clog2(N_TERMS)) begin : g_bad_acc_w
    $error("prod_accum: ACC_W too narrow for N_TERMS products");
  end

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(N_TERMS - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_next;

  assign prod_ext = {{(ACC_W-8){1'b0}}, prod_in};
  assign acc_next = acc + prod_ext;

  // Input side is open only while accumulating and not being cleared.
  assign in_ready  = (state == S_ACCUM) && !clr;
  // A result is presented exactly while the FSM holds it.
  assign out_valid = (state == S_HOLD);

  // Accumulate products, latch the total on the last term, hold until consumed.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state    <= S_ACCUM;
      acc      <= '0;
      term_cnt <= '0;
      sum_out  <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          // in_ready is 1 here since clr is low, so in_valid alone is an accept.
          if (in_valid) begin
            if (term_cnt == LAST_CNT) begin
              sum_out  <= acc_next;
              acc      <= '0;
              term_cnt <= '0;
              state    <= S_HOLD;
            end else begin
              acc      <= acc_next;
              term_cnt <= term_cnt + 5'd1;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state <= S_ACCUM;
          end
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Testbench for prod_accum: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_prod_accum;

  localparam int N = 4;
  localparam int W = 10;

  // Clock and DUT signals
  logic         clk = 1'b0;
  logic         rst, clr, in_valid, out_ready;
  logic [7:0]   prod_in;
  logic         in_ready, out_valid;
  logic [W-1:0] sum_out;
  logic [4:0]   term_cnt;

  always #5 clk = ~clk;

  prod_accum #(.N_TERMS(N), .ACC_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .prod_in   (prod_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .term_cnt  (term_cnt)
  );

  // Reference model: products of the current partial sum, pending result flag,
  // last result value, and the queue of results still owed to downstream.
  int           part_q[$];
  bit           holding = 1'b0;
  logic [W-1:0] exp_sum = '0;
  logic [W-1:0] exp_q[$];
  bit           known = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit r, input bit c, input bit v, input logic [7:0] p, input bit o);
    int s;
    rst = r; clr = c; in_valid = v; prod_in = p; out_ready = o;
    @(negedge clk);
    if (known) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !holding && !c});
      check("out_valid", {31'd0, out_valid}, {31'd0, holding});
      check("sum_out", {22'd0, sum_out}, {22'd0, exp_sum});
      check("term_cnt", {27'd0, term_cnt}, part_q.size());
      if (holding && o && !c && !r) begin
        check("consumed_result", {22'd0, sum_out}, {22'd0, exp_q.pop_front()});
      end
    end
    if (r || c) begin
      part_q.delete();
      exp_q.delete();
      holding = 1'b0;
      exp_sum = '0;
      known   = 1'b1;
    end else if (holding) begin
      if (o) holding = 1'b0;
    end else if (v) begin
      part_q.push_back(int'(p));
      if (part_q.size() == N) begin
        s = 0;
        foreach (part_q[i]) s += part_q[i];
        exp_sum = W'(s);
        exp_q.push_back(W'(s));
        holding = 1'b1;
        part_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          v, c, r, o, h, stall;
    logic [7:0]  p;

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; prod_in = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset values: rst with a valid 0xFF present accumulates nothing
    step(1, 0, 1, 8'hFF, 0);
    step(1, 0, 1, 8'hFF, 0);
    step(0, 0, 0, 8'h00, 0);

    // Full-scale sum with out_ready high, then a new sum starts
    repeat (4) step(0, 0, 1, 8'd225, 1);
    step(0, 0, 1, 8'd225, 1);           // hold/consume cycle, no accept
    repeat (4) step(0, 0, 1, 8'd225, 0); // next full-scale sum, left held
    step(0, 0, 0, 8'd0, 0);
    step(0, 0, 0, 8'd0, 0);

    // Clear versus consume in the same cycle
    step(0, 1, 0, 8'd0, 1);
    step(0, 0, 0, 8'd0, 1);

    // Backpressure: 3,5,7,9 then six stalled cycles with input 1 pending
    step(0, 0, 1, 8'd3, 0);
    step(0, 0, 1, 8'd5, 0);
    step(0, 0, 1, 8'd7, 0);
    step(0, 0, 1, 8'd9, 0);
    repeat (6) step(0, 0, 1, 8'd1, 0);
    step(0, 0, 1, 8'd1, 1);             // consume
    repeat (4) step(0, 0, 1, 8'd1, 1);  // sum of four 1s
    step(0, 0, 0, 8'd0, 1);

    // Gapped input
    step(0, 0, 1, 8'd10, 0);
    repeat (3) step(0, 0, 0, 8'd0, 0);
    step(0, 0, 1, 8'd20, 0);
    step(0, 0, 0, 8'd0, 0);
    step(0, 0, 1, 8'd30, 0);
    step(0, 0, 1, 8'd40, 0);
    step(0, 0, 0, 8'd0, 0);
    step(0, 0, 0, 8'd0, 1);

    // Clear mid-sum: 99 offered with clr is not accepted
    step(0, 0, 1, 8'd50, 0);
    step(0, 0, 1, 8'd60, 0);
    step(0, 1, 1, 8'd99, 0);
    step(0, 0, 1, 8'd1, 0);
    step(0, 0, 1, 8'd2, 0);
    step(0, 0, 1, 8'd3, 0);
    step(0, 0, 1, 8'd4, 0);
    step(0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 8'd0, 0);

    // Random traffic; a stalled product is held stable until accepted
    v = 1'b0; p = '0; stall = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!stall) begin
        v = ($urandom_range(0, 9) < 7);
        p = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
      end
      c = ($urandom_range(0, 31) == 0);
      r = ($urandom_range(0, 127) == 0);
      o = ($urandom_range(0, 1) == 1);
      h = holding;
      step(r, c, v, p, o);
      stall = v && (h || c || r);
    end
    step(0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 8'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
